// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Purpose  : Stall/flush sequencer for the five-stage pipeline: per-stage hold
//            vector, multi-cycle EX countdown, exception flush and redirect PC.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stallreq_id,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_cycles,
    input  logic              mem_wait,
    input  logic              flush_req,
    input  logic [31:0]       flush_target,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              ex_mc_busy,
    output logic              ex_mc_done,
    output logic [PERF_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [5:0]       c_HOLD_MEM  = 6'b011111;
    localparam logic [5:0]       c_HOLD_EX   = 6'b001111;
    localparam logic [5:0]       c_HOLD_ID   = 6'b000111;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [31:0]         r_new_pc;
    logic [PERF_W-1:0]   r_stall_count;
    logic                w_ex_hold;
    logic                w_done;
    logic [5:0]          w_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ex_hold   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ex_mc_start && (ex_mc_cycles != '0)) begin
                    w_ex_hold   = 1'b1;
                    w_state_nxt = ST_MC_BUSY;
                    w_count_nxt = ex_mc_cycles;
                end
            end
            ST_MC_BUSY: begin
                // A stalled memory stage freezes the countdown and defers completion.
                if (mem_wait) begin
                    w_ex_hold = 1'b1;
                end else if (r_count > c_CNT_ONE) begin
                    w_ex_hold   = 1'b1;
                    w_count_nxt = r_count - c_CNT_ONE;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
        endcase
        if (flush_req) begin
            w_state_nxt = ST_FLUSH;
            w_count_nxt = '0;
            w_done      = 1'b0;
        end
    end

    always_comb begin
        w_stall = 6'b000000;
        if (flush_req || (r_state == ST_FLUSH)) begin
            w_stall = 6'b000000;
        end else if (mem_wait) begin
            w_stall = c_HOLD_MEM;
        end else if (w_ex_hold) begin
            w_stall = c_HOLD_EX;
        end else if (stallreq_id) begin
            w_stall = c_HOLD_ID;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_new_pc <= '0;
        end else if (flush_req) begin
            r_new_pc <= flush_target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (stall[0] && (r_stall_count != {PERF_W{1'b1}})) begin
            r_stall_count <= r_stall_count + PERF_W'(1);
        end
    end

    // Combinational outputs are gated so nothing leaks from live inputs during reset.
    assign stall       = reset ? w_stall : 6'b000000;
    assign ex_mc_done  = reset & w_done;
    assign flush       = (r_state == ST_FLUSH);
    assign ex_mc_busy  = (r_state == ST_MC_BUSY);
    assign new_pc      = r_new_pc;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Purpose  : Directed scenarios plus random traffic against a cycle model of
//            the stall/flush rules for pipe_stall_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stall_ctrl;
    localparam int CNT_W  = 6;
    localparam int PERF_W = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              stallreq_id = 1'b0;
    logic              ex_mc_start = 1'b0;
    logic [CNT_W-1:0]  ex_mc_cycles = '0;
    logic              mem_wait = 1'b0;
    logic              flush_req = 1'b0;
    logic [31:0]       flush_target = '0;
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              ex_mc_busy;
    logic              ex_mc_done;
    logic [PERF_W-1:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clock(clock), .reset(reset), .stallreq_id(stallreq_id),
        .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles),
        .mem_wait(mem_wait), .flush_req(flush_req), .flush_target(flush_target),
        .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_busy(ex_mc_busy),
        .ex_mc_done(ex_mc_done), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    // Reference: m_left is the number of EX cycles still owed after the start cycle.
    int                m_left;
    logic              m_flush;
    logic [31:0]       m_pc;
    logic [PERF_W-1:0] m_perf;
    logic              e_hold, e_done, e_busy;
    logic [5:0]        e_stall;

    always_comb begin
        e_hold = (m_left == 0 && !m_flush && ex_mc_start && ex_mc_cycles != 0)
               || (m_left > 1) || (m_left > 0 && mem_wait);
        e_busy = (m_left > 0);
        e_done = reset && (m_left == 1) && !mem_wait && !flush_req;
        if (!reset || flush_req || m_flush) e_stall = 6'd0;
        else if (mem_wait)                  e_stall = 6'd31;
        else if (e_hold)                    e_stall = 6'd15;
        else if (stallreq_id)               e_stall = 6'd7;
        else                                e_stall = 6'd0;
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_left <= 0; m_flush <= 1'b0; m_pc <= '0; m_perf <= '0;
        end else begin
            if (e_stall[0] && m_perf != {PERF_W{1'b1}}) m_perf <= m_perf + 1'b1;
            m_flush <= flush_req;
            if (flush_req) begin
                m_pc <= flush_target;
                m_left <= 0;
            end else if (m_left > 0) begin
                m_left <= m_left - (mem_wait ? 0 : 1);
            end else if (!m_flush && ex_mc_start) begin
                m_left <= int'(ex_mc_cycles);
            end
        end
    end

    task automatic drive(input logic st, input logic [CNT_W-1:0] n, input logic mw,
                         input logic id, input logic fr, input logic [31:0] ft);
        @(negedge clock);
        ex_mc_start = st; ex_mc_cycles = n; mem_wait = mw;
        stallreq_id = id; flush_req = fr; flush_target = ft;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        ex_mc_start = 0; ex_mc_cycles = 0; mem_wait = 0;
        stallreq_id = 0; flush_req = 0; flush_target = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        mem_wait = 1'b1; stallreq_id = 1'b1;
        #1;
        vectors++;
        if ({stall, flush, ex_mc_busy, ex_mc_done, new_pc, stall_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: stall=%b flush=%b busy=%b done=%b pc=%h cnt=%h expected all 0",
                     stall, flush, ex_mc_busy, ex_mc_done, new_pc, stall_count);
        end
        @(negedge clock);
        reset = 1'b1; mem_wait = 0; stallreq_id = 0;
        drive(1, 6, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        vectors++;
        if (ex_mc_busy !== 1'b1 || stall !== 6'b011111) begin
            miscompares++;
            $display("FAIL reset_pre_busy: busy=%b stall=%b expected 1 011111", ex_mc_busy, stall);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({stall, flush, ex_mc_busy, ex_mc_done, new_pc, stall_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: stall=%b flush=%b busy=%b done=%b pc=%h cnt=%h expected all 0",
                     stall, flush, ex_mc_busy, ex_mc_done, new_pc, stall_count);
        end
        @(negedge clock);
        reset = 1'b1; mem_wait = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (stall !== 6'b000000 || ex_mc_busy !== 1'b0 || ex_mc_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: stall=%b busy=%b done=%b expected 000000 0 0",
                     stall, ex_mc_busy, ex_mc_done);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 0, 0, 1, 0, 0);
        vectors++;
        if (stall !== 6'b000111) begin
            miscompares++;
            $display("FAIL load_use_stall: got %b expected 000111", stall);
        end
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (stall !== 6'b000000 || stall_count !== 16'd1) begin
            miscompares++;
            $display("FAIL load_use_after: stall=%b cnt=%0d expected 000000 1", stall, stall_count);
        end
    endtask

    task automatic test_multicycle();
        logic [5:0] exp_s [4] = '{6'b001111, 6'b001111, 6'b001111, 6'b000000};
        logic       exp_b [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, (i == 0) ? 6'd3 : 6'd0, 0, 0, 0, 0);
            vectors++;
            if (stall !== exp_s[i] || ex_mc_busy !== exp_b[i] || ex_mc_done !== exp_d[i]) begin
                miscompares++;
                $display("FAIL multicycle_T+%0d: stall=%b busy=%b done=%b expected %b %b %b",
                         i, stall, ex_mc_busy, ex_mc_done, exp_s[i], exp_b[i], exp_d[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (ex_mc_busy !== 1'b0 || stall_count !== 16'd3) begin
            miscompares++;
            $display("FAIL multicycle_end: busy=%b cnt=%0d expected 0 3", ex_mc_busy, stall_count);
        end
    endtask

    task automatic test_mem_wait();
        logic [5:0] exp_s [5] = '{6'b001111, 6'b011111, 6'b011111, 6'b001111, 6'b000000};
        logic       exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       mw    [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(i == 0, (i == 0) ? 6'd2 : 6'd0, mw[i], 0, 0, 0);
            vectors++;
            if (stall !== exp_s[i] || ex_mc_done !== exp_d[i]) begin
                miscompares++;
                $display("FAIL mem_wait_T+%0d: stall=%b done=%b expected %b %b",
                         i, stall, ex_mc_done, exp_s[i], exp_d[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (ex_mc_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_wait_end: busy=%b expected 0", ex_mc_busy);
        end
    endtask

    task automatic test_flush();
        logic saw_done = 1'b0;
        do_reset();
        drive(1, 10, 0, 0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            saw_done |= ex_mc_done;
        end
        drive(0, 0, 0, 1, 1, 32'h0000_0020);
        vectors++;
        if (stall !== 6'b000000 || ex_mc_busy !== 1'b1 || flush !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_req_cycle: stall=%b busy=%b flush=%b expected 000000 1 0",
                     stall, ex_mc_busy, flush);
        end
        drive(0, 0, 0, 0, 1, 32'h0000_0040);
        vectors++;
        if (flush !== 1'b1 || new_pc !== 32'h20 || ex_mc_busy !== 1'b0 || stall !== 6'd0) begin
            miscompares++;
            $display("FAIL flush_cycle: flush=%b pc=%h busy=%b stall=%b expected 1 00000020 0 000000",
                     flush, new_pc, ex_mc_busy, stall);
        end
        drive(1, 4, 1, 1, 0, 0);
        vectors++;
        if (flush !== 1'b1 || new_pc !== 32'h40 || stall !== 6'd0) begin
            miscompares++;
            $display("FAIL flush_back_to_back: flush=%b pc=%h stall=%b expected 1 00000040 000000",
                     flush, new_pc, stall);
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            saw_done |= ex_mc_done;
        end
        vectors++;
        if (saw_done !== 1'b0 || flush !== 1'b0 || ex_mc_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_aftermath: saw_done=%b flush=%b busy=%b expected 0 0 0",
                     saw_done, flush, ex_mc_busy);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 0, 1, 1, 0, 0);
        vectors++;
        if (stall !== 6'b011111) begin
            miscompares++;
            $display("FAIL priority_stall: got %b expected 011111", stall);
        end
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (ex_mc_busy !== 1'b0 || stall !== 6'b000000) begin
            miscompares++;
            $display("FAIL priority_no_busy: busy=%b stall=%b expected 0 000000", ex_mc_busy, stall);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) == 0,
                  ($urandom_range(7) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(4)),
                  $urandom_range(3) == 0, $urandom_range(3) == 0,
                  $urandom_range(31) == 0, $urandom);
            vectors++;
            if ({stall, flush, ex_mc_busy, ex_mc_done, stall_count}
                    !== {e_stall, m_flush, e_busy, e_done, m_perf}
                || (m_flush && new_pc !== m_pc)) begin
                miscompares++;
                $display("FAIL random_%0d: stall=%b flush=%b busy=%b done=%b cnt=%h pc=%h expected %b %b %b %b %h %h",
                         i, stall, flush, ex_mc_busy, ex_mc_done, stall_count, new_pc,
                         e_stall, m_flush, e_busy, e_done, m_perf, m_pc);
            end
        end
    endtask

    task automatic test_saturation();
        drive(0, 0, 1, 0, 0, 0);
        repeat (70000) @(negedge clock);
        #1;
        vectors++;
        if (stall_count !== 16'hFFFF || m_perf !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL saturation: got %h model %h expected FFFF", stall_count, m_perf);
        end
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (stall_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL saturation_hold: got %h expected FFFF", stall_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_multicycle();
        test_mem_wait();
        test_flush();
        test_priority();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
